// File: rtl/clt_rng_pkg.sv
// Shared definitions for the CLT RNG statistics monitor: state encoding,
// derived accumulator widths and min/max seed values.
package clt_rng_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic int sum_width_f(input int data_width, input int log2_samples);
    return data_width + log2_samples;
  endfunction

  function automatic int sq_width_f(input int data_width, input int log2_samples);
    return 2 * data_width - 1 + log2_samples;
  endfunction

  // Min starts at the most positive value and max at the most negative value,
  // so the first accepted sample always replaces both.
  function automatic int min_init_f(input int data_width);
    return (1 << (data_width - 1)) - 1;
  endfunction

  function automatic int max_init_f(input int data_width);
    return -(1 << (data_width - 1));
  endfunction

endpackage

// File: rtl/clt_rng_stat_monitor_sq.sv
// Combinational signed squarer. The output is unsigned and 2*DATA_WIDTH-1 bits
// wide, which is enough for (-2^(DATA_WIDTH-1))^2.
module clt_rng_sq #(
  parameter int DATA_WIDTH = 12
) (
  input  logic signed [DATA_WIDTH-1:0]   a,
  output logic        [2*DATA_WIDTH-2:0] sq
);

  logic [DATA_WIDTH-1:0]   a_u;
  logic [DATA_WIDTH-1:0]   mag;
  logic [2*DATA_WIDTH-2:0] mag_ext;

  // Squaring the magnitude keeps the product unsigned. The magnitude of the
  // most negative input still fits in DATA_WIDTH unsigned bits.
  assign a_u     = a;
  assign mag     = a[DATA_WIDTH-1] ? (~a_u + DATA_WIDTH'(1)) : a_u;
  assign mag_ext = {{(DATA_WIDTH-1){1'b0}}, mag};
  assign sq      = mag_ext * mag_ext;

endmodule

// File: rtl/clt_rng_stat_monitor.sv
// Window statistics for the CLT Gaussian RNG stream: sum, sum of squares,
// min and max over 2^LOG2_SAMPLES qualified samples, offered on a valid/ready port.
module clt_rng_stat_monitor
  import clt_rng_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int LOG2_SAMPLES = 10,
  parameter int SUM_WIDTH    = sum_width_f(DATA_WIDTH, LOG2_SAMPLES),
  parameter int SQ_WIDTH     = sq_width_f(DATA_WIDTH, LOG2_SAMPLES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  output logic                         busy,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic signed [SUM_WIDTH-1:0]  sum_out,
  output logic        [SQ_WIDTH-1:0]   sumsq_out,
  output logic signed [DATA_WIDTH-1:0] mean_out,
  output logic signed [DATA_WIDTH-1:0] min_out,
  output logic signed [DATA_WIDTH-1:0] max_out
);

  localparam logic signed [DATA_WIDTH-1:0] MIN_INIT = DATA_WIDTH'(min_init_f(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = DATA_WIDTH'(max_init_f(DATA_WIDTH));

  state_t                         state_q, state_d;
  logic        [LOG2_SAMPLES-1:0] count_q, count_d;
  logic signed [SUM_WIDTH-1:0]    sum_q, sum_d;
  logic        [SQ_WIDTH-1:0]     sumsq_q, sumsq_d;
  logic signed [DATA_WIDTH-1:0]   min_q, min_d;
  logic signed [DATA_WIDTH-1:0]   max_q, max_d;

  logic        [2*DATA_WIDTH-2:0] sq;
  logic signed [SUM_WIDTH-1:0]    sample_ext;
  logic        [SQ_WIDTH-1:0]     sq_ext;

  clt_rng_sq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sq (
    .a (sample_in),
    .sq(sq)
  );

  assign sample_ext = {{LOG2_SAMPLES{sample_in[DATA_WIDTH-1]}}, sample_in};
  assign sq_ext     = {{LOG2_SAMPLES{1'b0}}, sq};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    sumsq_d = sumsq_q;
    min_d   = min_q;
    max_d   = max_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          count_d = '0;
          sum_d   = '0;
          sumsq_d = '0;
          min_d   = MIN_INIT;
          max_d   = MAX_INIT;
        end
      end
      ST_ACCUM: begin
        if (sample_valid) begin
          sum_d   = sum_q + sample_ext;
          sumsq_d = sumsq_q + sq_ext;
          count_d = count_q + LOG2_SAMPLES'(1);
          if (sample_in < min_q) min_d = sample_in;
          if (sample_in > max_q) max_d = sample_in;
          // The counter is at all-ones on the final sample of the window.
          if (&count_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before this edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sum_q   <= '0;
      sumsq_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      sumsq_q <= sumsq_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign busy         = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign result_valid = (state_q == ST_DONE);
  assign sum_out      = sum_q;
  assign sumsq_out    = sumsq_q;
  assign min_out      = min_q;
  assign max_out      = max_q;
  // Dropping the low LOG2_SAMPLES bits is the arithmetic shift, rounding toward -inf.
  assign mean_out     = sum_q[SUM_WIDTH-1:LOG2_SAMPLES];

endmodule

// File: tb/tb_clt_rng_stat_monitor.sv
// Directed bench for clt_rng_stat_monitor: a 4-sample instance for the short
// scenarios and a default-size instance for the full 1024-sample windows.
module tb_clt_rng_stat_monitor;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start_s = 1'b0;
  logic               start_f = 1'b0;
  logic signed [11:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               result_ready = 1'b0;

  logic               busy_s, rv_s;
  logic signed [13:0] sum_s;
  logic        [24:0] sumsq_s;
  logic signed [11:0] mean_s, min_s, max_s;

  logic               busy_f, rv_f;
  logic signed [21:0] sum_f;
  logic        [32:0] sumsq_f;
  logic signed [11:0] mean_f, min_f, max_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clt_rng_stat_monitor #(
    .DATA_WIDTH  (12),
    .LOG2_SAMPLES(2)
  ) dut_small (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .busy        (busy_s),
    .result_valid(rv_s),
    .result_ready(result_ready),
    .sum_out     (sum_s),
    .sumsq_out   (sumsq_s),
    .mean_out    (mean_s),
    .min_out     (min_s),
    .max_out     (max_s)
  );

  clt_rng_stat_monitor dut_full (
    .clk         (clk),
    .rst         (rst),
    .start       (start_f),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .busy        (busy_f),
    .result_valid(rv_f),
    .result_ready(result_ready),
    .sum_out     (sum_f),
    .sumsq_out   (sumsq_f),
    .mean_out    (mean_f),
    .min_out     (min_f),
    .max_out     (max_f)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v);
    sample_in    = v[11:0];
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start_s();
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
  endtask

  initial begin
    longint msum, msq;
    int     mmin, mmax, v;

    // Reset state
    tick(2);
    check("rst_busy", longint'(busy_s), 0);
    check("rst_rv", longint'(rv_s), 0);
    check("rst_sum", longint'(sum_s), 0);
    check("rst_sumsq", longint'(sumsq_s), 0);
    check("rst_min", longint'(min_s), 0);
    check("rst_max", longint'(max_s), 0);
    check("rst_mean", longint'(mean_s), 0);
    check("rst_busy_f", longint'(busy_f), 0);
    rst = 1'b0;
    tick(1);

    // Constant stream of 5s
    pulse_start_s();
    check("const_busy", longint'(busy_s), 1);
    repeat (3) send(5);
    check("const_rv_early", longint'(rv_s), 0);
    send(5);
    check("const_rv", longint'(rv_s), 1);
    check("const_sum", longint'(sum_s), 20);
    check("const_sumsq", longint'(sumsq_s), 100);
    check("const_min", longint'(min_s), 5);
    check("const_max", longint'(max_s), 5);
    check("const_mean", longint'(mean_s), 5);
    accept();
    check("const_idle_busy", longint'(busy_s), 0);
    check("const_idle_rv", longint'(rv_s), 0);
    check("const_idle_sum_kept", longint'(sum_s), 20);

    // Extreme values with gaps; a valid sample in the start cycle is ignored
    sample_in    = 12'sd100;
    sample_valid = 1'b1;
    pulse_start_s();
    sample_valid = 1'b0;
    check("ext_init_sum", longint'(sum_s), 0);
    check("ext_init_min", longint'(min_s), 2047);
    check("ext_init_max", longint'(max_s), -2048);
    send(-3);
    tick(3);
    send(7);
    tick(3);
    send(-2048);
    tick(3);
    check("ext_rv_gap", longint'(rv_s), 0);
    send(0);
    check("ext_rv", longint'(rv_s), 1);
    check("ext_sum", longint'(sum_s), -2044);
    check("ext_sumsq", longint'(sumsq_s), 4194362);
    check("ext_min", longint'(min_s), -2048);
    check("ext_max", longint'(max_s), 7);
    check("ext_mean", longint'(mean_s), -511);

    // Backpressure: samples and start are ignored while DONE waits
    for (int i = 0; i < 10; i++) begin
      sample_in    = 12'($urandom);
      sample_valid = 1'b1;
      start_s      = (i == 5);
      tick(1);
    end
    sample_valid = 1'b0;
    start_s      = 1'b0;
    check("bp_busy", longint'(busy_s), 1);
    check("bp_rv", longint'(rv_s), 1);
    check("bp_sum", longint'(sum_s), -2044);
    check("bp_sumsq", longint'(sumsq_s), 4194362);
    check("bp_min", longint'(min_s), -2048);
    check("bp_max", longint'(max_s), 7);
    accept();
    check("bp_busy_after", longint'(busy_s), 0);
    check("bp_rv_after", longint'(rv_s), 0);

    // Reset mid-window discards everything immediately
    pulse_start_s();
    send(9);
    send(9);
    rst = 1'b1;
    #1;
    check("mrst_busy", longint'(busy_s), 0);
    check("mrst_rv", longint'(rv_s), 0);
    check("mrst_sum", longint'(sum_s), 0);
    tick(1);
    rst = 1'b0;
    pulse_start_s();
    repeat (4) send(1);
    check("mrst_rv2", longint'(rv_s), 1);
    check("mrst_sum2", longint'(sum_s), 4);
    check("mrst_sumsq2", longint'(sumsq_s), 4);
    accept();

    // Start pulse during ACCUM does not restart the window
    pulse_start_s();
    send(2);
    pulse_start_s();
    send(3);
    send(4);
    check("sig_rv_early", longint'(rv_s), 0);
    send(5);
    check("sig_rv", longint'(rv_s), 1);
    check("sig_sum", longint'(sum_s), 14);
    check("sig_sumsq", longint'(sumsq_s), 54);
    check("sig_min", longint'(min_s), 2);
    check("sig_max", longint'(max_s), 5);
    accept();

    // Full default window of the most negative sample
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    repeat (1023) send(-2048);
    check("full_rv_early", longint'(rv_f), 0);
    send(-2048);
    check("full_rv", longint'(rv_f), 1);
    check("full_sum", longint'(sum_f), -2097152);
    check("full_sumsq", longint'(sumsq_f), 64'd4294967296);
    check("full_min", longint'(min_f), -2048);
    check("full_max", longint'(max_f), -2048);
    check("full_mean", longint'(mean_f), -2048);
    accept();
    check("full_idle_busy", longint'(busy_f), 0);

    // Full window of a near-zero-mean pattern against a running model
    msum = 0;
    msq  = 0;
    mmin = 2047;
    mmax = -2048;
    start_f = 1'b1;
    tick(1);
    start_f = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      v = ((i * 37) % 201) - 100;
      msum += v;
      msq  += longint'(v) * v;
      if (v < mmin) mmin = v;
      if (v > mmax) mmax = v;
      send(v);
    end
    check("pat_rv", longint'(rv_f), 1);
    check("pat_sum", longint'(sum_f), msum);
    check("pat_sumsq", longint'(sumsq_f), msq);
    check("pat_min", longint'(min_f), mmin);
    check("pat_max", longint'(max_f), mmax);
    check("pat_mean", longint'(mean_f), msum >>> 10);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clt_rng_stat_monitor.md
Name: clt_rng_stat_monitor

Overview:
Receiving end of the CLT Gaussian RNG sample stream.
Consumes signed two's-complement samples, one per clock when qualified, over a window of 2^LOG2_SAMPLES samples.
For each window it accumulates the sum, the sum of squares, the minimum and the maximum, then presents them through a valid/ready result port.
Sits beside the RNG in the SPGD perturbation path and provides on-chip distribution checks (mean ≈ 0, variance, range).

Parameters:
DATA_WIDTH, 12, sample width; matches the RNG output width.
LOG2_SAMPLES, 10, log2 of the window length (window = 1024 samples).
SUM_WIDTH, DATA_WIDTH+LOG2_SAMPLES, signed sum accumulator width (derived; do not override).
SQ_WIDTH, 2*DATA_WIDTH-1+LOG2_SAMPLES, unsigned sum-of-squares width (derived; do not override).

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; arms a new window.
sample_in  in  DATA_WIDTH  signed RNG sample.
sample_valid  in  1  sample_in is qualified this cycle.
busy  out  1  high in ACCUM and DONE.
result_valid  out  1  result fields are valid.
result_ready  in  1  consumer accepts the result.
sum_out  out  SUM_WIDTH  signed sum of the window.
sumsq_out  out  SQ_WIDTH  unsigned sum of squares.
mean_out  out  DATA_WIDTH  sum_out arithmetically shifted right by LOG2_SAMPLES, truncated to DATA_WIDTH.
min_out  out  DATA_WIDTH  signed minimum sample.
max_out  out  DATA_WIDTH  signed maximum sample.

Behaviour:
- States: IDLE, ACCUM, DONE.
- Reset: asynchronous. State returns to IDLE. All accumulators, sample counter, busy and result_valid go to 0. sum_out, sumsq_out, mean_out, min_out and max_out read 0.
- IDLE, start=1: next state ACCUM. On the same edge:
  - sum = 0, sumsq = 0, count = 0.
  - min = most positive value (0x7FF at default width).
  - max = most negative value (0x800 at default width).
  - A sample_valid asserted in the start cycle is ignored.
- ACCUM, each edge with sample_valid=1:
  - sum += sign-extended sample.
  - sumsq += sample*sample, where the square is 2*DATA_WIDTH-1 bits, unsigned.
  - min/max update with signed compare.
  - count += 1.
  - sample_valid=0 cycles change nothing; gaps are allowed.
- Window end: on the edge that accepts sample number 2^LOG2_SAMPLES (count at all-ones), the state moves to DONE. The registered accumulators include that final sample. result_valid is high in the cycle after that edge, so latency is 1 cycle from the last accepted sample.
- DONE:
  - result_valid=1; all result outputs held stable.
  - sample_valid and start are ignored.
  - On an edge with result_ready=1: next state IDLE, result_valid clears.
  - Result fields keep their last values in IDLE until the next start.
- start while in ACCUM or DONE: ignored; the window is not restarted.
- Overflow: none possible. The worst case is 2^LOG2_SAMPLES samples of -2^(DATA_WIDTH-1). At default widths that gives sum -2^21 (fits 22-bit signed) and sumsq 2^32 (fits 33 bits).
- mean_out: combinational from the registered sum. The shift is arithmetic, i.e. it rounds toward negative infinity.
- rst asserted mid-window or mid-handshake: everything is discarded and the block returns to IDLE immediately.

Decomposition:
- Shared package clt_rng_pkg holds:
  - the state enum (IDLE/ACCUM/DONE);
  - the width-derivation functions for SUM_WIDTH and SQ_WIDTH;
  - the min/max init constants as functions of DATA_WIDTH.
- One sub-module is natural: clt_rng_sq, a registered-free signed squarer. It takes a DATA_WIDTH input and produces a 2*DATA_WIDTH-1 bit unsigned output, so it can later be swapped for a DSP-mapped version.
- The FSM, counter and accumulators stay in the top level.

Test Plan:
- Constant stream (LOG2_SAMPLES=2): start, then 4 samples of 5 -> result_valid one cycle after the 4th sample, with sum=20, sumsq=100, min=5, max=5, mean=5.
- Extreme values (LOG2_SAMPLES=2): samples -3, 7, -2048, 0 with sample_valid gaps of 3 idle cycles between them -> sum=-2044, sumsq=4194362, min=-2048, max=7, mean=-511.
- Backpressure: hold result_ready=0 for 10 cycles after result_valid, driving random samples and a start pulse -> outputs unchanged and busy=1. Then raise result_ready=1 for one cycle -> IDLE, busy=0.
- Full window at default size: 1024 samples of -2048 -> sum=-2097152, sumsq=4294967296, no wrap. Then connect the live RNG for a window -> |mean| ≤ 8 and min ≥ -2048.
- Reset mid-window: assert rst after 2 of 4 samples -> busy=0 and result_valid=0 immediately. Then start with 4 samples of 1 -> sum=4, with no residue from the first window.
- Start ignored: pulse start after 1 sample in ACCUM -> the window still completes after 3 more samples, with sum equal to all 4 samples.
